// File: rtl/stack_cmd_ctrl_if.sv
// Command bundle between the BASYS3 button/switch front-end and the LIFO stack.
// master = board/stack side (drives raw inputs), slave = stack_cmd_ctrl.
interface stack_cmd_ctrl_if #(
   parameter int DATA_SIZE = 8
);
   logic                 btn_push;
   logic                 btn_pop;
   logic [DATA_SIZE-1:0] sw_data;
   logic                 stack_full;
   logic                 stack_empty;
   logic                 err_clr;
   logic                 push;
   logic                 pop;
   logic [DATA_SIZE-1:0] push_data;
   logic                 err_overflow;
   logic                 err_underflow;

   modport master (
      output btn_push, btn_pop, sw_data, stack_full, stack_empty, err_clr,
      input  push, pop, push_data, err_overflow, err_underflow
   );

   modport slave (
      input  btn_push, btn_pop, sw_data, stack_full, stack_empty, err_clr,
      output push, pop, push_data, err_overflow, err_underflow
   );
endinterface

// File: rtl/stack_cmd_ctrl.sv
// Push/pop button front-end for the LIFO stack: synchronise, debounce, one command per press.
// Optional auto-repeat while a single button is held: define STACK_CMD_AUTOREPEAT_EN.
module stack_cmd_ctrl #(
   parameter int DATA_SIZE     = 8,
   parameter int DB_CYCLES     = 1000000,
   parameter int REPEAT_CYCLES = 50000000
) (
   input  logic            clk,
   input  logic            reset,
   stack_cmd_ctrl_if.slave cmd
);
   localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   if (DB_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("stack_cmd_ctrl: DB_CYCLES must be >= 1 and REPEAT_CYCLES >= 2");
   end

   typedef enum logic [1:0] {IDLE, ISSUE_PUSH, ISSUE_POP, HOLD} state_t;

   // Bit 0 is the push button, bit 1 the pop button throughout.
   logic [1:0]                 btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [DATA_SIZE-1:0]       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [1:0]                 db_q, db_d, db_prev_q, db_prev_d;
   logic [1:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
   logic [1:0]                 press;
   state_t                     state_q, state_d;
   logic [DATA_SIZE-1:0]       push_data_q, push_data_d;
   logic                       err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
   logic                       do_push, do_pop, ovf_set, unf_set;
`ifdef STACK_CMD_AUTOREPEAT_EN
   localparam int               REP_W    = $clog2(REPEAT_CYCLES);
   // Fires one cycle early so the ISSUE cycle completes the REPEAT_CYCLES period.
   localparam logic [REP_W-1:0] REP_FIRE = REP_W'(REPEAT_CYCLES - 2);
   logic [REP_W-1:0]            rep_cnt_q, rep_cnt_d;
`endif

   always_comb begin
      btn_s1_d  = {cmd.btn_pop, cmd.btn_push};
      btn_s2_d  = btn_s1_q;
      sw_s1_d   = cmd.sw_data;
      sw_s2_d   = sw_s1_q;
      db_prev_d = db_q;
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      db_d      = db_q;
      db_cnt_d  = db_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (btn_s2_q[i] == db_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            db_d[i]     = ~db_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end
      end
   end

   assign press = db_q & ~db_prev_q;

   always_comb begin
      state_d     = state_q;
      push_data_d = push_data_q;
      err_ovf_d   = err_ovf_q;
      err_unf_d   = err_unf_q;
      do_push     = 1'b0;
      do_pop      = 1'b0;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;
`ifdef STACK_CMD_AUTOREPEAT_EN
      rep_cnt_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            do_push = press[0];
            do_pop  = press[1] & ~press[0];
         end
         ISSUE_PUSH, ISSUE_POP: state_d = HOLD;
         HOLD: begin
            if (db_q == 2'b00) begin
               state_d = IDLE;
            end
`ifdef STACK_CMD_AUTOREPEAT_EN
            else if ($onehot(db_q)) begin
               if (rep_cnt_q == REP_FIRE) begin
                  do_push = db_q[0];
                  do_pop  = db_q[1];
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      // Shared command evaluation for both fresh presses and auto-repeats.
      if (do_push) begin
         if (cmd.stack_full) begin
            ovf_set = 1'b1;
            state_d = HOLD;
         end else begin
            push_data_d = sw_s2_q;
            state_d     = ISSUE_PUSH;
         end
      end else if (do_pop) begin
         if (cmd.stack_empty) begin
            unf_set = 1'b1;
            state_d = HOLD;
         end else begin
            state_d = ISSUE_POP;
         end
      end

      if (cmd.err_clr) begin
         err_ovf_d = 1'b0;
         err_unf_d = 1'b0;
      end
      if (ovf_set) err_ovf_d = 1'b1;
      if (unf_set) err_unf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         db_q        <= '0;
         db_prev_q   <= '0;
         db_cnt_q    <= '0;
         state_q     <= IDLE;
         push_data_q <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
`ifdef STACK_CMD_AUTOREPEAT_EN
         rep_cnt_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
         btn_s1_q    <= btn_s1_d;
         btn_s2_q    <= btn_s2_d;
         sw_s1_q     <= sw_s1_d;
         sw_s2_q     <= sw_s2_d;
         db_q        <= db_d;
         db_prev_q   <= db_prev_d;
         db_cnt_q    <= db_cnt_d;
         state_q     <= state_d;
         push_data_q <= push_data_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
`ifdef STACK_CMD_AUTOREPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
`endif
      end
   end

   assign cmd.push          = (state_q == ISSUE_PUSH);
   assign cmd.pop           = (state_q == ISSUE_POP);
   assign cmd.push_data     = push_data_q;
   assign cmd.err_overflow  = err_ovf_q;
   assign cmd.err_underflow = err_unf_q;
endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Self-checking bench for stack_cmd_ctrl with a behavioural model and directed press scenarios.
module tb_stack_cmd_ctrl;
   localparam int DS = 8;
   localparam int DB = 4;
   localparam int RP = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stack_cmd_ctrl_if #(.DATA_SIZE(DS)) bus ();

   stack_cmd_ctrl #(.DATA_SIZE(DS), .DB_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
      .clk   (clk),
      .reset (rst),
      .cmd   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model: levels pass a 2-stage delay, a level is accepted once DB
   // consecutive synced samples disagree with it, and a press is acted on only when idle.
   logic [1:0]    m_s1, m_s2, m_deb, m_prev, m_press;
   logic [DS-1:0] m_sw1, m_sw2;
   logic [DB-1:0] m_hist [2];
   logic          m_busy, m_nbusy, m_fp, m_fpop, m_np, m_npop;
   logic          e_push, e_pop, e_ovf, e_unf;
   logic [DS-1:0] e_data;
   int            m_rep;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
         m_sw1 = '0; m_sw2 = '0; m_hist[0] = '0; m_hist[1] = '0;
         m_busy = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
         e_data = '0; m_rep = 0;
      end else begin
         m_press = m_deb & ~m_prev;
         m_fp = 1'b0; m_fpop = 1'b0; m_np = 1'b0; m_npop = 1'b0;
         m_nbusy = m_busy;
         if (!m_busy) begin
            m_fp   = m_press[0];
            m_fpop = m_press[1] & ~m_press[0];
         end else if (!e_push && !e_pop && m_deb == 2'b00) begin
            m_nbusy = 1'b0;
         end
`ifdef STACK_CMD_AUTOREPEAT_EN
         if (m_busy && !e_push && !e_pop && (m_deb == 2'b01 || m_deb == 2'b10)) begin
            if (m_rep == RP - 2) begin
               m_rep  = 0;
               m_fp   = m_deb[0];
               m_fpop = m_deb[1];
            end else begin
               m_rep++;
            end
         end else begin
            m_rep = 0;
         end
`endif
         if (bus.err_clr) begin
            e_ovf = 1'b0;
            e_unf = 1'b0;
         end
         if (m_fp) begin
            m_nbusy = 1'b1;
            if (bus.stack_full) e_ovf = 1'b1;
            else begin
               m_np   = 1'b1;
               e_data = m_sw2;
            end
         end else if (m_fpop) begin
            m_nbusy = 1'b1;
            if (bus.stack_empty) e_unf = 1'b1;
            else m_npop = 1'b1;
         end
         e_push = m_np;
         e_pop  = m_npop;
         m_busy = m_nbusy;

         m_prev = m_deb;
         for (int i = 0; i < 2; i++) begin
            m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
            if (m_hist[i] == {DB{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
         end
         m_s2  = m_s1;
         m_s1  = {bus.btn_pop, bus.btn_push};
         m_sw2 = m_sw1;
         m_sw1 = bus.sw_data;
      end
   end

   // Every-cycle comparison against the model, plus pulse bookkeeping.
   int            push_cnt = 0;
   int            pop_cnt  = 0;
   logic [DS-1:0] last_data = '0;

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_push",      bus.push,          e_push);
         check("cmp_pop",       bus.pop,           e_pop);
         check("cmp_push_data", bus.push_data,     e_data);
         check("cmp_err_ovf",   bus.err_overflow,  e_ovf);
         check("cmp_err_unf",   bus.err_underflow, e_unf);
         check("cmp_exclusive", bus.push & bus.pop, 1'b0);
         if (bus.push) begin
            push_cnt++;
            last_data = bus.push_data;
         end
         if (bus.pop) pop_cnt++;
      end
   end

   task automatic press_btn(input bit is_pop, input int hold, input int gap);
      if (is_pop) bus.btn_pop = 1'b1; else bus.btn_push = 1'b1;
      step(hold);
      if (is_pop) bus.btn_pop = 1'b0; else bus.btn_push = 1'b0;
      step(gap);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int p0, q0, k;

   initial begin
      rst = 1'b1;
      bus.btn_push = 1'b0; bus.btn_pop = 1'b0; bus.sw_data = '0;
      bus.stack_full = 1'b0; bus.stack_empty = 1'b0; bus.err_clr = 1'b0;
      step(3);
      check("rst_push",      bus.push,          1'b0);
      check("rst_pop",       bus.pop,           1'b0);
      check("rst_push_data", bus.push_data,     8'h00);
      check("rst_err_ovf",   bus.err_overflow,  1'b0);
      check("rst_err_unf",   bus.err_underflow, 1'b0);
      rst = 1'b0;
      step(2);

      // Clean long press: one push carrying the switch value, which then holds.
      p0 = push_cnt; q0 = pop_cnt;
      bus.sw_data = 8'hA5;
      press_btn(1'b0, 20, 15);
      check("t1_push_count", push_cnt - p0, 1);
      check("t1_push_data",  last_data, 8'hA5);
      check("t1_pop_count",  pop_cnt - q0, 0);
      bus.sw_data = 8'h3C;
      step(5);
      check("t1_data_held", bus.push_data, 8'hA5);

      // Bounce every 2 cycles never survives a 4-cycle debounce.
      p0 = push_cnt;
      for (int i = 0; i < 30; i++) begin
         bus.btn_push = ((i / 2) % 2) == 0;
         step(1);
      end
      bus.btn_push = 1'b0;
      step(15);
      check("t2_no_push", push_cnt - p0, 0);

      // Push refused while full; clear afterwards.
      p0 = push_cnt;
      bus.stack_full = 1'b1;
      press_btn(1'b0, 10, 12);
      check("t3_no_push",  push_cnt - p0, 0);
      check("t3_ovf_set",  bus.err_overflow, 1'b1);
      bus.err_clr = 1'b1;
      step(1);
      bus.err_clr = 1'b0;
      step(1);
      check("t3_ovf_clr",  bus.err_overflow, 1'b0);
      bus.stack_full = 1'b0;

      // Pop refused while empty, then accepted; underflow stays sticky.
      q0 = pop_cnt;
      bus.stack_empty = 1'b1;
      press_btn(1'b1, 10, 12);
      check("t4_no_pop",   pop_cnt - q0, 0);
      check("t4_unf_set",  bus.err_underflow, 1'b1);
      bus.stack_empty = 1'b0;
      press_btn(1'b1, 10, 12);
      check("t4_one_pop",  pop_cnt - q0, 1);
      check("t4_unf_sticky", bus.err_underflow, 1'b1);
      bus.err_clr = 1'b1;
      step(1);
      bus.err_clr = 1'b0;
      step(1);
      check("t4_unf_clr",  bus.err_underflow, 1'b0);

      // Simultaneous press: push wins; pop re-press while push held is ignored.
      p0 = push_cnt; q0 = pop_cnt;
      bus.sw_data = 8'h5A;
      bus.btn_push = 1'b1; bus.btn_pop = 1'b1;
      step(10);
      bus.btn_pop = 1'b0;
      step(8);
      bus.btn_pop = 1'b1;
      step(10);
      bus.btn_push = 1'b0; bus.btn_pop = 1'b0;
      step(12);
      check("t5_push_count", push_cnt - p0, 1);
      check("t5_pop_count",  pop_cnt - q0, 0);
      check("t5_push_data",  last_data, 8'h5A);
      check("t5_no_ovf",     bus.err_overflow, 1'b0);
      check("t5_no_unf",     bus.err_underflow, 1'b0);
      press_btn(1'b1, 10, 12);
      check("t5_pop_after_release", pop_cnt - q0, 1);

      // Reset during the strobe cycle drops push at once; controller idles afterwards.
      bus.btn_push = 1'b1;
      k = 0;
      while (!bus.push && k < 40) begin
         step(1);
         k++;
      end
      check("t6_push_seen", bus.push, 1'b1);
      rst = 1'b1;
      bus.btn_push = 1'b0;
      #1;
      check("t6_async_drop", bus.push, 1'b0);
      step(2);
      rst = 1'b0;
      step(3);
      q0 = pop_cnt;
      press_btn(1'b1, 10, 12);
      check("t6_idle_after_reset", pop_cnt - q0, 1);

`ifdef STACK_CMD_AUTOREPEAT_EN
      // Held push: initial pulse plus repeats every RP cycles.
      begin
         int n_pulses, last_j;
         bus.sw_data = 8'h11;
         bus.btn_push = 1'b1;
         k = 0;
         while (!bus.push && k < 40) begin
            step(1);
            k++;
         end
         check("t7_first_push", bus.push, 1'b1);
         n_pulses = 1;
         last_j   = 0;
         for (int j = 1; j <= 70; j++) begin
            step(1);
            if (j == 5) bus.sw_data = 8'h22;
            if (bus.push) begin
               n_pulses++;
               check("t7_spacing", j - last_j, RP);
               last_j = j;
            end
         end
         bus.btn_push = 1'b0;
         step(15);
         check("t7_pulse_count", n_pulses, 4);
         check("t7_recaptured",  last_data, 8'h22);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stack_cmd_ctrl.md
Name: stack_cmd_ctrl

Overview:
- Upstream command front-end for the LIFO stack on BASYS3.
- Converts raw push/pop push-buttons and slide-switch data into clean single-cycle push/pop strobes plus a held data word, ready for the stack's push, pop and push_data_in inputs.
- Synchronises and debounces the buttons, issues exactly one command per press, and refuses commands the stack cannot accept (full/empty), recording the refusal in sticky error flags.

Parameters:
- DATA_SIZE, 8, width of data word; matches the stack's DATA_SIZE.
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- REPEAT_CYCLES, 50000000, auto-repeat period in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_push  in  1  raw push button, asynchronous to clk, bouncy.
- btn_pop  in  1  raw pop button, asynchronous to clk, bouncy.
- sw_data  in  DATA_SIZE  raw slide switches, asynchronous, quasi-static.
- stack_full  in  1  full flag from the stack.
- stack_empty  in  1  empty flag from the stack.
- err_clr  in  1  synchronous clear of both sticky error flags.
- push  out  1  one-cycle push strobe to the stack.
- pop  out  1  one-cycle pop strobe to the stack.
- push_data  out  DATA_SIZE  data word for the stack; stable while push is high.
- err_overflow  out  1  sticky: a push was refused because stack_full was high.
- err_underflow  out  1  sticky: a pop was refused because stack_empty was high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset values:
  - push = 0, pop = 0, push_data = 0, err_overflow = 0, err_underflow = 0.
  - Debounced levels = 0; counters = 0; FSM = IDLE.
  - Reset mid-command drops any strobe immediately.
- Synchroniser: btn_push, btn_pop and sw_data each pass through a 2-flop synchroniser.
- Debounce, per button:
  - A counter increments while the synced level differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DB_CYCLES-1, the debounced level flips and the counter clears.
  - A pulse shorter than DB_CYCLES cycles is never accepted.
- Edge detect: a press event is a debounced rising edge (registered debounced level, 0 to 1).
- FSM states: IDLE, ISSUE_PUSH, ISSUE_POP, HOLD.
  - IDLE, push press, stack_full=0: capture synced sw_data into push_data, go to ISSUE_PUSH.
  - IDLE, push press, stack_full=1: set err_overflow, go to HOLD, no strobe.
  - IDLE, pop press (no push press), stack_empty=0: go to ISSUE_POP.
  - IDLE, pop press (no push press), stack_empty=1: set err_underflow, go to HOLD, no strobe.
  - Push and pop press in the same cycle: push has priority and the pop press is discarded, with no error flag.
  - ISSUE_PUSH: push=1 for exactly one cycle, then go to HOLD.
  - ISSUE_POP: pop=1 for exactly one cycle, then go to HOLD.
  - HOLD: wait until both debounced levels are 0, then go to IDLE. Presses in HOLD are ignored.
- Output timing:
  - push and pop are decoded from registered state only, so they are glitch-free and never high together.
  - Strobe latency is 1 cycle after the press event.
  - push_data holds its value until the next accepted push.
- Errors:
  - err_clr=1 clears both flags on the next edge.
  - If a set and a clear occur in the same cycle, set wins.

Optional Feature:
- Macro: STACK_CMD_AUTOREPEAT_EN.
- When defined:
  - Adds a repeat counter in HOLD while exactly one button's debounced level is high.
  - Every REPEAT_CYCLES cycles, it re-evaluates that command exactly as in IDLE: strobe, or set the error flag.
  - push_data is re-captured from the switches on each repeated push.
  - The counter clears on entering HOLD and on release.
- When undefined: exactly one command per press; no repeat counter is synthesised.

Test Plan (DB_CYCLES=4, REPEAT_CYCLES=20):
- After reset, sw_data=8'hA5 and btn_push held high for 20 cycles -> exactly one push pulse, push_data=8'hA5 during the pulse, pop stays 0.
- btn_push toggling every 2 cycles for 30 cycles, then low -> no push pulse; debounce counter never completes.
- stack_full=1 with a clean push press -> no push pulse, err_overflow=1; then err_clr pulse -> err_overflow=0.
- stack_empty=1 with a pop press -> no pop pulse, err_underflow=1. Then stack_empty=0 with a second press after release -> one pop pulse.
- Both buttons rise on the same cycle -> one push pulse, no pop pulse, no error; a new press is ignored until both buttons are released.
- Reset asserted on the ISSUE_PUSH cycle -> push drops to 0 asynchronously and the FSM is in IDLE after release. With STACK_CMD_AUTOREPEAT_EN, holding push for 70 cycles past the press -> 1 initial plus 3 repeat push pulses, each 20 cycles apart.
